// File: rtl/if_map_load_ctrl.sv
// IF-map window load sequencer. It reads one row of the 8 SRAM banks per cycle
// and drives the 8x8 window buffer's load enables, lane selects and local clears.
module if_map_load_ctrl #(
   parameter int ADDR_W = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [3:0]            K,
   input  logic [2:0]            x_off,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W-1:0]     row_words,
   output logic                  Rd_en,
   output logic [8*ADDR_W-1:0]   Rd_addr,
   output logic [63:0]           Reg_loads,
   output logic [191:0]          Mux_Sel,
   output logic [63:0]           Local_Reset,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_LAST,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t                r_state;
   logic [3:0]            r_k;
   logic [2:0]            r_x_off;
   logic [ADDR_W-1:0]     r_row_words;
   logic [ADDR_W-1:0]     r_row_base;
   logic [3:0]            r_row;
   logic                  r_rd_en;
   logic [8*ADDR_W-1:0]   r_rd_addr;
   logic [63:0]           r_reg_loads;
   logic [191:0]          r_mux_sel;
   logic [63:0]           r_local_reset;
   logic                  r_busy;
   logic                  r_done;

   logic [3:0]            w_k_eff;
   logic [191:0]          w_mux_sel;
   logic [63:0]           w_local_reset;
   logic [7:0]            w_col_mask;
   logic [2:0]            w_load_row;
   logic [63:0]           w_row_load;

   // Banks left of the window start column hold the next column group.
   function automatic logic [8*ADDR_W-1:0] f_bank_addrs(
      input logic [ADDR_W-1:0] row_base,
      input logic [2:0]        xo
   );
      logic [8*ADDR_W-1:0] addrs;
      addrs = '0;
      for (int b = 0; b < 8; b++) begin
         addrs[b*ADDR_W +: ADDR_W] = (3'(b) < xo) ? (row_base + ADDR_ONE) : row_base;
      end
      return addrs;
   endfunction

   always_comb begin
      // NOTE: every signal gets a default before the loops so no latch is inferred.
      w_mux_sel     = '0;
      w_local_reset = '0;
      w_col_mask    = '0;
      w_k_eff       = ((K == 4'd0) || (K > 4'd8)) ? 4'd8 : K;
      for (int i = 0; i < 64; i++) begin
         w_mux_sel[i*3 +: 3] = x_off + 3'(i % 8);
         w_local_reset[i]    = (4'(i / 8) >= w_k_eff) || (4'(i % 8) >= w_k_eff);
      end
      for (int c = 0; c < 8; c++) begin
         w_col_mask[c] = (4'(c) < r_k);
      end
      // Loads target the row whose read was issued in the current cycle.
      w_load_row = 3'(r_row - 4'd1);
      w_row_load = {56'd0, w_col_mask} << {w_load_row, 3'b000};
   end

   // NOTE: all state and registered outputs update with non-blocking assignments.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_k           <= '0;
         r_x_off       <= '0;
         r_row_words   <= '0;
         r_row_base    <= '0;
         r_row         <= '0;
         r_rd_en       <= 1'b0;
         r_rd_addr     <= '0;
         r_reg_loads   <= '0;
         r_mux_sel     <= '0;
         r_local_reset <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_reg_loads <= '0;
               r_done      <= 1'b0;
               if (start) begin
                  r_k           <= w_k_eff;
                  r_x_off       <= x_off;
                  r_row_words   <= row_words;
                  r_mux_sel     <= w_mux_sel;
                  r_local_reset <= w_local_reset;
                  r_rd_en       <= 1'b1;
                  r_rd_addr     <= f_bank_addrs(base_addr, x_off);
                  r_row_base    <= base_addr + row_words;
                  r_row         <= 4'd1;
                  r_busy        <= 1'b1;
                  r_state       <= S_READ;
               end
            end
            S_READ: begin
               r_local_reset <= '0;
               r_reg_loads   <= w_row_load;
               if (r_row < r_k) begin
                  r_rd_addr  <= f_bank_addrs(r_row_base, r_x_off);
                  r_row_base <= r_row_base + r_row_words;
                  r_row      <= r_row + 4'd1;
               end else begin
                  r_rd_en <= 1'b0;
                  r_state <= S_LAST;
               end
            end
            S_LAST: begin
               r_reg_loads <= '0;
               r_busy      <= 1'b0;
               r_done      <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign Rd_en       = r_rd_en;
   assign Rd_addr     = r_rd_addr;
   assign Reg_loads   = r_reg_loads;
   assign Mux_Sel     = r_mux_sel;
   assign Local_Reset = r_local_reset;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule

// File: tb/tb_if_map_load_ctrl.sv
// Bench for if_map_load_ctrl: directed and random window loads compared
// cycle by cycle against an arithmetic model of the load sequence.
module tb_if_map_load_ctrl;

   localparam int AW = 10;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic [3:0]          K;
   logic [2:0]          x_off;
   logic [AW-1:0]       base_addr;
   logic [AW-1:0]       row_words;
   logic                Rd_en;
   logic [8*AW-1:0]     Rd_addr;
   logic [63:0]         Reg_loads;
   logic [191:0]        Mux_Sel;
   logic [63:0]         Local_Reset;
   logic                busy;
   logic                done;

   int checks = 0;
   int errors = 0;

   if_map_load_ctrl #(.ADDR_W(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .K           (K),
      .x_off       (x_off),
      .base_addr   (base_addr),
      .row_words   (row_words),
      .Rd_en       (Rd_en),
      .Rd_addr     (Rd_addr),
      .Reg_loads   (Reg_loads),
      .Mux_Sel     (Mux_Sel),
      .Local_Reset (Local_Reset),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " Rd_en"},       192'(Rd_en),       192'(0));
      check({tag, " Rd_addr"},     192'(Rd_addr),     192'(0));
      check({tag, " Reg_loads"},   192'(Reg_loads),   192'(0));
      check({tag, " Mux_Sel"},     Mux_Sel,           192'(0));
      check({tag, " Local_Reset"}, 192'(Local_Reset), 192'(0));
      check({tag, " busy"},        192'(busy),        192'(0));
      check({tag, " done"},        192'(done),        192'(0));
   endtask

   // Expected outputs in cycle n after the start edge, from the load rules.
   task automatic check_cycle(input int n, input int ke, input int xo, input int base, input int rw);
      logic [63:0]     e_loads;
      logic [63:0]     e_lrst;
      logic [191:0]    e_mux;
      logic [8*AW-1:0] e_addr;
      int              rowi;
      e_loads = '0;
      e_lrst  = '0;
      e_mux   = '0;
      e_addr  = '0;
      if (n >= 2 && n <= ke + 1)
         for (int c = 0; c < ke; c++) e_loads[(n-2)*8 + c] = 1'b1;
      if (n == 1)
         for (int i = 0; i < 64; i++) e_lrst[i] = (i / 8 >= ke) || (i % 8 >= ke);
      for (int i = 0; i < 64; i++) e_mux[i*3 +: 3] = 3'((xo + i % 8) % 8);
      rowi = (n <= ke) ? n - 1 : ke - 1;
      for (int b = 0; b < 8; b++)
         e_addr[b*AW +: AW] = AW'((base + rowi * rw + ((b < xo) ? 1 : 0)) % (1 << AW));
      check($sformatf("c%0d Rd_en", n),       192'(Rd_en),       192'(n >= 1 && n <= ke));
      check($sformatf("c%0d busy", n),        192'(busy),        192'(n >= 1 && n <= ke + 1));
      check($sformatf("c%0d done", n),        192'(done),        192'(n == ke + 2));
      check($sformatf("c%0d Reg_loads", n),   192'(Reg_loads),   192'(e_loads));
      check($sformatf("c%0d Local_Reset", n), 192'(Local_Reset), 192'(e_lrst));
      check($sformatf("c%0d Mux_Sel", n),     Mux_Sel,           e_mux);
      check($sformatf("c%0d Rd_addr", n),     192'(Rd_addr),     192'(e_addr));
   endtask

   // One load from start through the first IDLE cycle; inputs are scrambled
   // after the start edge to show they were latched.
   task automatic run_load(input int k, input int xo, input int base, input int rw,
                           input int repulse_at, input bit hold, input int abort_at);
      int ke;
      ke        = (k == 0 || k > 8) ? 8 : k;
      K         = 4'(k);
      x_off     = 3'(xo);
      base_addr = AW'(base);
      row_words = AW'(rw);
      start     = 1'b1;
      tick();
      for (int n = 1; n <= ke + 3; n++) begin
         if (!hold) start = 1'b0;
         check_cycle(n, ke, xo, base, rw);
         if (n == abort_at) begin
            start = 1'b0;
            reset = 1'b0;
            #1;
            check_zero($sformatf("mid_reset c%0d", n));
            #1;
            reset = 1'b1;
            return;
         end
         if (n == ke + 3) return;
         K         = 4'($urandom);
         x_off     = 3'($urandom);
         base_addr = AW'($urandom);
         row_words = AW'($urandom);
         if (n == repulse_at) start = 1'b1;
         tick();
      end
   endtask

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      K         = '0;
      x_off     = '0;
      base_addr = '0;
      row_words = '0;
      tick();
      tick();
      check_zero("reset");
      reset = 1'b1;
      tick();
      check_zero("idle_after_reset");

      run_load(3, 0, 100, 20, 0, 1'b0, 0);
      run_load(8, 5, 0, 4, 0, 1'b0, 0);
      run_load(0, 2, 37, 11, 0, 1'b0, 0);
      run_load(12, 7, 500, 100, 0, 1'b0, 0);
      run_load(2, 1, 1020, 3, 0, 1'b0, 0);
      run_load(4, 3, 200, 50, 2, 1'b0, 0);
      run_load(8, 6, 300, 9, 0, 1'b0, 3);
      run_load(5, 4, 64, 8, 0, 1'b0, 0);
      run_load(1, 7, 1023, 1023, 0, 1'b1, 0);
      run_load(6, 2, 10, 700, 0, 1'b0, 0);

      for (int t = 0; t < 10; t++)
         run_load($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 1023),
                  $urandom_range(0, 1023), 0, 1'b0, 0);

      tick();
      check_zero_but_held();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Idle after a load: control strobes quiet while lane selects stay put.
   task automatic check_zero_but_held;
      check("final Rd_en",       192'(Rd_en),       192'(0));
      check("final Reg_loads",   192'(Reg_loads),   192'(0));
      check("final Local_Reset", 192'(Local_Reset), 192'(0));
      check("final busy",        192'(busy),        192'(0));
      check("final done",        192'(done),        192'(0));
   endtask

endmodule
